// File: rtl/pad_cond_pkg.sv
// Shared defaults for the pad input conditioner.
// Channel count, synchroniser depth and filter counter width.
package pad_cond_pkg;

  localparam int DEF_NCH         = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 4;
  localparam int CNT_MAX         = 2**DEF_CNT_W - 1;

endpackage

// File: rtl/pad_cond_chan.sv
// One conditioned pad channel: sync chain, glitch filter, edges.
// din toggles only after filt_len+1 consecutive disagreeing samples.
module pad_cond_chan
  import pad_cond_pkg::*;
#(
  parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int   CNT_W       = DEF_CNT_W,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             vpwr_good,
  input  logic             en,
  input  logic [CNT_W-1:0] filt_len,
  input  logic             pad_in,
  output logic             din,
  output logic             rise,
  output logic             fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  logic                   s;
  logic                   differ;
  logic                   flip;

  assign s      = sync[SYNC_STAGES-1];
  assign differ = (s != din);
  assign flip   = en && differ && (cnt >= filt_len);

  // Loss of pad power behaves like reset but is applied on the clock.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sync <= {SYNC_STAGES{RESET_VAL}};
      din  <= RESET_VAL;
      cnt  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else if (!vpwr_good) begin
      sync <= {SYNC_STAGES{RESET_VAL}};
      din  <= RESET_VAL;
      cnt  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pad_in};
      rise <= flip & s;
      fall <= flip & ~s;
      if (flip) begin
        din <= s;
      end
      if (!en || !differ || flip) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pad_input_conditioner.sv
// Clocked pad input conditioner: NCH independent filtered channels.
// Threshold and power-good are shared across all channels.
module pad_input_conditioner
  import pad_cond_pkg::*;
#(
  parameter int   NCH         = DEF_NCH,
  parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int   CNT_W       = DEF_CNT_W,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             vpwr_good,
  input  logic [NCH-1:0]   en,
  input  logic [CNT_W-1:0] filt_len,
  input  logic [NCH-1:0]   pad_in,
  output logic [NCH-1:0]   din,
  output logic [NCH-1:0]   rise,
  output logic [NCH-1:0]   fall
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES must be 2..4");
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    pad_cond_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W),
      .RESET_VAL   (RESET_VAL)
    ) u_chan (
      .clk       (clk),
      .resetb    (resetb),
      .vpwr_good (vpwr_good),
      .en        (en[i]),
      .filt_len  (filt_len),
      .pad_in    (pad_in[i]),
      .din       (din[i]),
      .rise      (rise[i]),
      .fall      (fall[i])
    );
  end

endmodule
